// File: rtl/mem_bist_master.sv
// Memory BIST traffic master: writes an LFSR pattern over the valid/ready bus,
// reads it back and checks every word, with per-request timeout protection.
module mem_bist_master #(
  parameter int unsigned      ADDR_WIDTH = 5,
  parameter int unsigned      WIDTH      = 8,
  parameter int unsigned      NUM_TXN    = 32,
  parameter logic [WIDTH-1:0] SEED       = WIDTH'(8'h01),
  parameter logic [WIDTH-1:0] TAPS       = WIDTH'(8'hB8),
  parameter int unsigned      TIMEOUT    = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  wr_rd,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic [WIDTH-1:0]      wdata,
  output logic                  valid,
  input  logic                  ready,
  input  logic [WIDTH-1:0]      rdata,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [ADDR_WIDTH:0]   err_cnt,
  output logic [ADDR_WIDTH-1:0] first_err_addr,
  output logic                  timeout_err
);

  localparam int unsigned      CW       = ADDR_WIDTH + 1;
  localparam int unsigned      TW       = $clog2(TIMEOUT + 1);
  localparam logic [WIDTH-1:0] SEED_EFF = (SEED == '0) ? WIDTH'(1) : SEED;
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(NUM_TXN - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_REQ,
    S_WR_GAP,
    S_RD_REQ,
    S_RD_GAP
  } state_t;

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_idx;
  logic [WIDTH-1:0]      r_lfsr;
  logic [TW-1:0]         r_tmo_cnt;

  logic [WIDTH-1:0]      w_lfsr_next;
  logic [ADDR_WIDTH-1:0] w_idx_next;
  logic                  w_last;
  logic                  w_mismatch;
  logic                  w_tmo_hit;
  logic [CW-1:0]         w_err_inc;

  assign w_lfsr_next = (r_lfsr >> 1) ^ (r_lfsr[0] ? TAPS : '0);
  assign w_idx_next  = r_idx + ADDR_WIDTH'(1);
  assign w_last      = (r_idx == LAST_IDX);
  assign w_mismatch  = (rdata != r_lfsr);
  assign w_tmo_hit   = (r_tmo_cnt == TW'(TIMEOUT - 1));
  assign w_err_inc   = (err_cnt == '1) ? err_cnt : err_cnt + CW'(1);

  // Single-process FSM; every output is a register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= S_IDLE;
      r_idx          <= '0;
      r_lfsr         <= '0;
      r_tmo_cnt      <= '0;
      wr_rd          <= 1'b0;
      addr           <= '0;
      wdata          <= '0;
      valid          <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      err_cnt        <= '0;
      first_err_addr <= '0;
      timeout_err    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            err_cnt        <= '0;
            first_err_addr <= '0;
            timeout_err    <= 1'b0;
            pass           <= 1'b0;
            r_lfsr         <= SEED_EFF;
            r_idx          <= '0;
            r_tmo_cnt      <= '0;
            busy           <= 1'b1;
            valid          <= 1'b1;
            wr_rd          <= 1'b1;
            addr           <= '0;
            wdata          <= SEED_EFF;
            r_state        <= S_WR_REQ;
          end
        end

        S_WR_REQ: begin
          if (ready) begin
            valid   <= 1'b0;
            wr_rd   <= 1'b0;
            addr    <= '0;
            wdata   <= '0;
            r_state <= S_WR_GAP;
          end else if (w_tmo_hit) begin
            timeout_err <= 1'b1;
            valid       <= 1'b0;
            wr_rd       <= 1'b0;
            addr        <= '0;
            wdata       <= '0;
            busy        <= 1'b0;
            done        <= 1'b1;
            pass        <= 1'b0;
            r_state     <= S_IDLE;
          end else begin
            r_tmo_cnt <= r_tmo_cnt + TW'(1);
          end
        end

        S_WR_GAP: begin
          r_tmo_cnt <= '0;
          valid     <= 1'b1;
          if (w_last) begin
            r_lfsr  <= SEED_EFF;
            r_idx   <= '0;
            wr_rd   <= 1'b0;
            addr    <= '0;
            wdata   <= '0;
            r_state <= S_RD_REQ;
          end else begin
            r_lfsr  <= w_lfsr_next;
            r_idx   <= w_idx_next;
            wr_rd   <= 1'b1;
            addr    <= w_idx_next;
            wdata   <= w_lfsr_next;
            r_state <= S_WR_REQ;
          end
        end

        S_RD_REQ: begin
          if (ready) begin
            if (w_mismatch) begin
              err_cnt <= w_err_inc;
              if (err_cnt == '0) first_err_addr <= r_idx;
            end
            valid <= 1'b0;
            wr_rd <= 1'b0;
            addr  <= '0;
            wdata <= '0;
            if (w_last) begin
              busy    <= 1'b0;
              done    <= 1'b1;
              pass    <= (err_cnt == '0) && !w_mismatch;
              r_state <= S_IDLE;
            end else begin
              r_state <= S_RD_GAP;
            end
          end else if (w_tmo_hit) begin
            timeout_err <= 1'b1;
            valid       <= 1'b0;
            wr_rd       <= 1'b0;
            addr        <= '0;
            wdata       <= '0;
            busy        <= 1'b0;
            done        <= 1'b1;
            pass        <= 1'b0;
            r_state     <= S_IDLE;
          end else begin
            r_tmo_cnt <= r_tmo_cnt + TW'(1);
          end
        end

        S_RD_GAP: begin
          r_tmo_cnt <= '0;
          r_lfsr    <= w_lfsr_next;
          r_idx     <= w_idx_next;
          valid     <= 1'b1;
          wr_rd     <= 1'b0;
          addr      <= w_idx_next;
          wdata     <= '0;
          r_state   <= S_RD_REQ;
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bist_master.sv
// Directed bench for mem_bist_master with a simple one-cycle-latency memory model.
module tb_mem_bist_master;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       wr_rd;
  logic [4:0] addr;
  logic [7:0] wdata;
  logic       valid;
  logic       ready = 1'b0;
  logic [7:0] rdata;
  logic       busy;
  logic       done;
  logic       pass;
  logic [5:0] err_cnt;
  logic [4:0] first_err_addr;
  logic       timeout_err;

  int checks   = 0;
  int failures = 0;
  int e        = 0;
  int early;
  int done_e;
  int vcnt;

  logic       mem_en     = 1'b0;
  logic       corrupt_en = 1'b0;
  logic [7:0] mem [32];
  logic [7:0] exp_w [5];

  mem_bist_master dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .wr_rd          (wr_rd),
    .addr           (addr),
    .wdata          (wdata),
    .valid          (valid),
    .ready          (ready),
    .rdata          (rdata),
    .busy           (busy),
    .done           (done),
    .pass           (pass),
    .err_cnt        (err_cnt),
    .first_err_addr (first_err_addr),
    .timeout_err    (timeout_err)
  );

  always #5 clk = ~clk;

  // Memory: ready follows valid by one cycle; addr 2 optionally reads back with bit 0 flipped.
  always @(posedge clk) begin
    ready <= mem_en & valid;
    if (valid && ready && wr_rd) mem[addr] <= wdata;
  end

  always_comb rdata = mem[addr] ^ ((corrupt_en && addr == 5'd2 && !wr_rd) ? 8'h01 : 8'h00);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    e++;
  endtask

  task automatic launch();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    e     = 0;
    start = 1'b0;
  endtask

  task automatic chk_idle_bus(input string tag);
    chk({tag, "_valid"}, valid, 0);
    chk({tag, "_wr_rd"}, wr_rd, 0);
    chk({tag, "_addr"},  addr,  0);
    chk({tag, "_wdata"}, wdata, 0);
  endtask

  initial begin
    exp_w[0] = 8'h01; exp_w[1] = 8'hB8; exp_w[2] = 8'h5C; exp_w[3] = 8'h2E; exp_w[4] = 8'h17;
    for (int i = 0; i < 32; i++) mem[i] = 8'h00;
    rst   = 1'b1;
    start = 1'b1;

    // Reset held with start asserted
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_busy", busy, 0);
      chk("rst_valid", valid, 0);
    end
    chk_idle_bus("rst");
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_err_cnt", err_cnt, 0);
    chk("rst_first", first_err_addr, 0);
    chk("rst_tmo", timeout_err, 0);
    @(negedge clk);
    rst   = 1'b0;
    start = 1'b0;
    mem_en = 1'b1;
    tick();

    // Clean run
    launch();
    chk("c0_valid", valid, 1);
    chk("c0_wr_rd", wr_rd, 1);
    chk("c0_addr", addr, 0);
    chk("c0_wdata", wdata, 8'h01);
    chk("c0_busy", busy, 1);
    early = 0;
    while (e < 191) begin
      tick();
      if (done) early++;
      if (e == 2) chk("c_acc0_valid", valid, 0);
      if (e == 3 || e == 6 || e == 9) begin
        chk("c_wr_valid", valid, 1);
        chk("c_wr_wr_rd", wr_rd, 1);
        chk("c_wr_addr", addr, e / 3);
        chk("c_wr_wdata", wdata, exp_w[e/3]);
      end
      if (e == 96) begin
        chk("c_rd0_valid", valid, 1);
        chk("c_rd0_wr_rd", wr_rd, 0);
        chk("c_rd0_addr", addr, 0);
        chk("c_rd0_wdata", wdata, 0);
      end
    end
    chk("c_done_pulses", early, 1);
    chk("c_done", done, 1);
    chk("c_busy_end", busy, 0);
    chk("c_pass", pass, 1);
    chk("c_err_cnt", err_cnt, 0);
    chk("c_tmo", timeout_err, 0);
    chk_idle_bus("c_end");
    tick();
    chk("c_done_drop", done, 0);
    chk("c_pass_hold", pass, 1);

    // Corrupted readback at addr 2
    corrupt_en = 1'b1;
    launch();
    chk("x_pass_clr", pass, 0);
    done_e = -1;
    while (done_e < 0 && e < 300) begin
      tick();
      if (done) done_e = e;
    end
    chk("x_done_edge", done_e, 191);
    chk("x_err_cnt", err_cnt, 1);
    chk("x_first", first_err_addr, 2);
    chk("x_pass", pass, 0);
    chk("x_busy", busy, 0);

    // Stuck ready -> timeout
    corrupt_en = 1'b0;
    mem_en     = 1'b0;
    launch();
    chk("t_err_clr", err_cnt, 0);
    chk("t_first_clr", first_err_addr, 0);
    vcnt = 0;
    while (valid && vcnt < 40) begin
      vcnt++;
      tick();
    end
    chk("t_valid_cycles", vcnt, 16);
    chk("t_tmo", timeout_err, 1);
    chk("t_done", done, 1);
    chk("t_pass", pass, 0);
    chk("t_busy", busy, 0);
    chk_idle_bus("t_bus");
    tick();
    chk("t_done_drop", done, 0);
    chk("t_tmo_sticky", timeout_err, 1);

    // Reset during read of addr 5
    mem_en = 1'b1;
    launch();
    chk("r_tmo_clr", timeout_err, 0);
    while (e < 111) tick();
    chk("r_rd5_valid", valid, 1);
    chk("r_rd5_wr_rd", wr_rd, 0);
    chk("r_rd5_addr", addr, 5);
    #2;
    rst = 1'b1;
    #1;
    chk_idle_bus("r_async");
    chk("r_async_busy", busy, 0);
    chk("r_async_done", done, 0);
    @(negedge clk);
    rst   = 1'b0;
    start = 1'b1;
    @(posedge clk);
    #1;
    e     = 0;
    start = 1'b0;
    chk("r_restart_valid", valid, 1);
    chk("r_restart_wr_rd", wr_rd, 1);
    chk("r_restart_addr", addr, 0);
    chk("r_restart_wdata", wdata, 8'h01);

    // Start pulsed while busy, then held across done
    while (e < 9) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("b_busy", busy, 1);
    chk("b_addr", addr, 3);
    while (e < 12) tick();
    chk("b_wr4_addr", addr, 4);
    chk("b_wr4_wdata", wdata, 8'h17);
    early = 0;
    while (e < 190) begin
      tick();
      if (done) early++;
    end
    chk("b_no_early_done", early, 0);
    start = 1'b1;
    tick();
    chk("b_done", done, 1);
    chk("b_pass", pass, 1);
    chk("b_busy_end", busy, 0);
    tick();
    chk("b_rerun_valid", valid, 1);
    chk("b_rerun_wr_rd", wr_rd, 1);
    chk("b_rerun_addr", addr, 0);
    chk("b_rerun_wdata", wdata, 8'h01);
    chk("b_rerun_busy", busy, 1);
    chk("b_rerun_done", done, 0);
    chk("b_rerun_pass", pass, 0);
    start = 1'b0;
    rst   = 1'b1;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
